alu_seq: RTL and testbench

- Parametrised, registered successor to the calculator's combinational ALU; sits between the expression parser and the result/display path.
- Adds signed/unsigned operation and a start/busy/done handshake.
- Multiply and divide are iterative (one bit per cycle); divide returns quotient and remainder and flags divide-by-zero.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_iter_core.sv | 87 ++++++++
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential calculator ALU: operations, FSM states,
// operand interpretation and the iterative core's mode select.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_e;

   typedef enum logic {
      DT_UNSIGNED = 1'b0,
      DT_SIGNED   = 1'b1
   } dtype_e;

   typedef enum logic {
      MODE_MUL = 1'b0,
      MODE_DIV = 1'b1
   } iter_mode_e;

endpackage

// File: rtl/alu_iter_core.sv
// Magnitude-only iterative datapath shared by multiply (shift-add) and divide
// (restoring), one bit per cycle for WIDTH cycles after the start edge.
module alu_iter_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  iter_mode_e         mode,
   input  logic [WIDTH-1:0]   mag_a,
   input  logic [WIDTH-1:0]   mag_b,
   output logic               done,
   output logic [2*WIDTH-1:0] raw
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   iter_mode_e         mode_q, mode_d;
   logic               run_q, run_d;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH-1:0]   trial;

   // Mul keeps {high partial, multiplier} and shifts right; div keeps
   // {remainder, dividend/quotient} and shifts left.
   always_comb begin
      acc_d   = acc_q;
      opb_d   = opb_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      run_d   = run_q;
      sum     = '0;
      shifted = '0;
      trial   = '0;
      if (start) begin
         acc_d  = {{WIDTH{1'b0}}, mag_a};
         opb_d  = mag_b;
         cnt_d  = '0;
         mode_d = mode;
         run_d  = 1'b1;
      end else if (run_q) begin
         if (cnt_q == CW'(WIDTH)) begin
            run_d = 1'b0;
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (mode_q == MODE_MUL) begin
               sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
               acc_d = {sum, acc_q[WIDTH-1:1]};
            end else begin
               shifted = acc_q[2*WIDTH-1:WIDTH-1];
               trial   = shifted[WIDTH-1:0] - opb_q;
               if (shifted >= {1'b0, opb_q}) begin
                  acc_d = {trial, acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         opb_q  <= '0;
         cnt_q  <= '0;
         mode_q <= MODE_MUL;
         run_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         opb_q  <= opb_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         run_q  <= run_d;
      end
   end

   assign done = run_q && (cnt_q == CW'(WIDTH));
   assign raw  = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered calculator ALU with start/busy/done handshake: single-cycle add/sub,
// iterative signed/unsigned mul and div with quotient/remainder and div-by-zero flag.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               data_type,
   input  logic [1:0]         op,
   input  logic               parser_done,
   output logic               busy,
   output logic [2*WIDTH-1:0] cal_result,
   output logic               alu_done,
   output logic               div_zero
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   op_e                op_q, op_d;
   dtype_e             dt_q, dt_d;
   logic [2*WIDTH-1:0] cal_q, cal_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic               capture;
   logic               core_start;
   logic               in_signed;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic               core_done;
   logic [2*WIDTH-1:0] core_raw;
   logic               neg_a, neg_b, neg_res;
   logic [2*WIDTH-1:0] ext_a, ext_b;
   logic [WIDTH-1:0]   quo, rem;
   logic               finish, zero_div;

   // The core is loaded on the capture edge itself, so its magnitudes come
   // straight from the input operands rather than the capture registers.
   assign capture    = (state_q == ST_IDLE) && parser_done;
   assign core_start = capture && ((op_e'(op) == OP_MUL) ||
                                   ((op_e'(op) == OP_DIV) && (b != '0)));
   assign in_signed  = (dtype_e'(data_type) == DT_SIGNED);
   assign mag_a      = (in_signed && a[WIDTH-1]) ? -a : a;
   assign mag_b      = (in_signed && b[WIDTH-1]) ? -b : b;

   alu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk   (clk),
      .rst   (rst),
      .start (core_start),
      .mode  ((op_e'(op) == OP_DIV) ? MODE_DIV : MODE_MUL),
      .mag_a (mag_a),
      .mag_b (mag_b),
      .done  (core_done),
      .raw   (core_raw)
   );

   assign neg_a   = (dt_q == DT_SIGNED) && a_q[WIDTH-1];
   assign neg_b   = (dt_q == DT_SIGNED) && b_q[WIDTH-1];
   assign neg_res = neg_a ^ neg_b;
   assign ext_a   = {{WIDTH{neg_a}}, a_q};
   assign ext_b   = {{WIDTH{neg_b}}, b_q};
   assign quo     = core_raw[WIDTH-1:0];
   assign rem     = core_raw[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      dt_d     = dt_q;
      cal_d    = cal_q;
      done_d   = 1'b0;
      dz_d     = dz_q;
      finish   = 1'b0;
      zero_div = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (parser_done) begin
               state_d = ST_EXEC;
               a_d     = a;
               b_d     = b;
               op_d    = op_e'(op);
               dt_d    = dtype_e'(data_type);
            end
         end
         ST_EXEC: begin
            case (op_q)
               OP_ADD: begin
                  cal_d  = ext_a + ext_b;
                  finish = 1'b1;
               end
               OP_SUB: begin
                  cal_d  = ext_a - ext_b;
                  finish = 1'b1;
               end
               OP_MUL: begin
                  if (core_done) begin
                     cal_d  = neg_res ? -core_raw : core_raw;
                     finish = 1'b1;
                  end
               end
               OP_DIV: begin
                  // Divide-by-zero bypasses the core entirely.
                  if (b_q == '0) begin
                     cal_d    = {a_q, {WIDTH{1'b1}}};
                     zero_div = 1'b1;
                     finish   = 1'b1;
                  end else if (core_done) begin
                     cal_d  = {(neg_a ? -rem : rem), (neg_res ? -quo : quo)};
                     finish = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         default: state_d = ST_IDLE;
      endcase
      if (finish) begin
         state_d = ST_IDLE;
         done_d  = 1'b1;
         dz_d    = zero_div;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         dt_q    <= DT_UNSIGNED;
         cal_q   <= '0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         dt_q    <= dt_d;
         cal_q   <= cal_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign busy       = (state_q == ST_EXEC);
   assign cal_result = cal_q;
   assign alu_done   = done_q;
   assign div_zero   = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq at WIDTH=16: expected results and
// latencies are queued at capture and checked when alu_done pulses.
module tb_alu_seq;

   localparam int WIDTH  = 16;
   localparam int BUDGET = 40;

   logic              clk;
   logic              rst;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              data_type;
   logic [1:0]        op;
   logic              parser_done;
   logic              busy;
   logic [2*WIDTH-1:0] cal_result;
   logic              alu_done;
   logic              div_zero;

   typedef struct {
      logic [31:0] result;
      logic        dz;
      int          latency;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cycle_cnt  = 0;
   int   cap_cycle  = 0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .a           (a),
      .b           (b),
      .data_type   (data_type),
      .op          (op),
      .parser_done (parser_done),
      .busy        (busy),
      .cal_result  (cal_result),
      .alu_done    (alu_done),
      .div_zero    (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drives one start strobe from just after an edge; the next edge is the capture edge.
   task automatic applyStimulus(input string tag, input logic [15:0] av, input logic [15:0] bv,
                                input logic dt, input logic [1:0] opv, input logic [31:0] res,
                                input logic dz, input int lat, input bit push);
      exp_t e;
      a           = av;
      b           = bv;
      data_type   = dt;
      op          = opv;
      parser_done = 1'b1;
      @(posedge clk);
      #1;
      parser_done = 1'b0;
      cap_cycle   = cycle_cnt;
      compareValue({tag, "_busy_after_capture"}, {31'd0, busy}, 32'd1);
      if (push) begin
         e.result  = res;
         e.dz      = dz;
         e.latency = lat;
         e.tag     = tag;
         sb.push_back(e);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      bit   seen;
      e    = sb.pop_front();
      seen = 1'b0;
      for (int k = 0; k < BUDGET; k++) begin
         @(posedge clk);
         #1;
         if (alu_done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         compareValue({e.tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      end else begin
         compareValue({e.tag, "_result"}, cal_result, e.result);
         compareValue({e.tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, e.dz});
         compareValue({e.tag, "_latency"}, 32'(cycle_cnt - cap_cycle), 32'(e.latency));
         compareValue({e.tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      rst         = 1'b1;
      a           = '0;
      b           = '0;
      data_type   = 1'b0;
      op          = 2'b00;
      parser_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      compareValue("reset_result", cal_result, 32'h0);
      compareValue("reset_done", {31'd0, alu_done}, 32'd0);
      compareValue("reset_busy", {31'd0, busy}, 32'd0);
      compareValue("reset_div_zero", {31'd0, div_zero}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      applyStimulus("add_u_carry", 16'hFFFF, 16'h0001, 1'b0, 2'b00, 32'h0001_0000, 1'b0, 1, 1'b1);
      checkOutput();
      applyStimulus("sub_s_3m5", 16'h0003, 16'h0005, 1'b1, 2'b01, 32'hFFFF_FFFE, 1'b0, 1, 1'b1);
      checkOutput();
      applyStimulus("sub_u_3m5", 16'h0003, 16'h0005, 1'b0, 2'b01, 32'hFFFF_FFFE, 1'b0, 1, 1'b1);
      checkOutput();
      applyStimulus("add_s_neg", 16'h8000, 16'hFFFF, 1'b1, 2'b00, 32'hFFFF_7FFF, 1'b0, 1, 1'b1);
      checkOutput();
      applyStimulus("mul_s_m3x7", 16'hFFFD, 16'h0007, 1'b1, 2'b10, 32'hFFFF_FFEB, 1'b0, 17, 1'b1);
      checkOutput();
      applyStimulus("mul_u_max", 16'hFFFF, 16'hFFFF, 1'b0, 2'b10, 32'hFFFE_0001, 1'b0, 17, 1'b1);
      checkOutput();
      applyStimulus("div_u_100d7", 16'd100, 16'd7, 1'b0, 2'b11, 32'h0002_000E, 1'b0, 17, 1'b1);
      checkOutput();
      applyStimulus("div_s_m7d2", 16'hFFF9, 16'h0002, 1'b1, 2'b11, 32'hFFFF_FFFD, 1'b0, 17, 1'b1);
      checkOutput();
      applyStimulus("div_s_minm1", 16'h8000, 16'hFFFF, 1'b1, 2'b11, 32'h0000_8000, 1'b0, 17, 1'b1);
      checkOutput();
      applyStimulus("div_zero", 16'h1234, 16'h0000, 1'b0, 2'b11, 32'h1234_FFFF, 1'b1, 1, 1'b1);
      checkOutput();
      applyStimulus("add_after_dz", 16'h0001, 16'h0001, 1'b0, 2'b00, 32'h0000_0002, 1'b0, 1, 1'b1);
      checkOutput();

      // A start strobe during a multiply must be dropped, not queued.
      applyStimulus("mul_ignore", 16'hFFFD, 16'h0007, 1'b1, 2'b10, 32'hFFFF_FFEB, 1'b0, 17, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      a           = 16'h0001;
      b           = 16'h0001;
      op          = 2'b00;
      parser_done = 1'b1;
      @(posedge clk);
      #1;
      parser_done = 1'b0;
      checkOutput();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         compareValue("no_queued_op", {31'd0, alu_done}, 32'd0);
      end

      // Asynchronous reset in the middle of a divide.
      applyStimulus("div_abort", 16'd100, 16'd7, 1'b0, 2'b11, 32'h0, 1'b0, 0, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      compareValue("abort_result", cal_result, 32'h0);
      compareValue("abort_busy", {31'd0, busy}, 32'd0);
      compareValue("abort_done", {31'd0, alu_done}, 32'd0);
      compareValue("abort_div_zero", {31'd0, div_zero}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus("add_after_rst", 16'h0002, 16'h0003, 1'b0, 2'b00, 32'h0000_0005, 1'b0, 1, 1'b1);
      checkOutput();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
